// File: rtl/grid_pkg.sv
// Shared grid geometry and loader state encoding for the life engine and its feeder.
package grid_pkg;

    localparam int GRID_ROWS = 16;
    localparam int GRID_COLS = 16;

    typedef enum logic {
        FILL = 1'b0,
        LOAD = 1'b1
    } loader_state_t;

endpackage

// File: rtl/grid_loader.sv
// Assembles a frame row by row over valid/ready and commits it to the life engine with a one-cycle load.
// Optional feature: define GRID_LOADER_ABORT_EN to add the abort input that discards a partial frame.
module grid_loader
    import grid_pkg::*;
#(
    parameter int ROWS = GRID_ROWS,
    parameter int COLS = GRID_COLS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 row_valid,
    output logic                 row_ready,
    input  logic [COLS-1:0]      row_data,
    input  logic                 row_last,
`ifdef GRID_LOADER_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 load,
    output logic [ROWS*COLS-1:0] in_data,
    output logic                 busy,
    output logic                 frame_err
);

    localparam int RW = $clog2(ROWS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    loader_state_t state;
    loader_state_t state_next;
    logic [RW-1:0] r;
    logic [RW-1:0] r_next;
    logic          write_row;
    logic          err_next;
    logic          abort_req;

`ifdef GRID_LOADER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Ready is held low during reset so no row can be taken before the frame is cleared.
    assign row_ready = (state == FILL) && !reset;
    assign busy      = (r != '0) || (state == LOAD);

    always_comb begin
        state_next = state;
        r_next     = r;
        write_row  = 1'b0;
        err_next   = 1'b0;
        case (state)
            FILL: begin
                if (abort_req) begin
                    r_next = '0;
                end else if (row_valid && row_ready) begin
                    write_row = 1'b1;
                    // row_last must coincide exactly with the final row index.
                    if (row_last != (r == LAST_ROW)) begin
                        err_next = 1'b1;
                        r_next   = '0;
                    end else if (row_last) begin
                        r_next     = '0;
                        state_next = LOAD;
                    end else begin
                        r_next = r + 1'b1;
                    end
                end
            end
            LOAD: begin
                state_next = FILL;
            end
            default: begin
                state_next = FILL;
                r_next     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FILL;
            r         <= '0;
            in_data   <= '0;
            load      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            r         <= r_next;
            load      <= (state_next == LOAD);
            frame_err <= err_next;
            if (write_row) begin
                in_data[COLS*r +: COLS] <= row_data;
            end
        end
    end

endmodule
